// File: rtl/sdr_receive_duc_if.sv
// sdr_receive_duc_if
//   Bundles the Ethernet-receive side, the DUC FIFO write side and the
//   status outputs of sdr_receive_duc.
//   slave  : the receiver block (consumes payload bytes, drives FIFO/status)
//   master : the environment (drives payload bytes, run, fifo_full)
interface sdr_receive_duc_if;
  logic        run;             // radio running
  logic        udp_rx_active;   // high for the payload bytes of one packet
  logic [7:0]  udp_rx_data;     // payload byte
  logic [15:0] to_port;         // UDP destination port of current packet
  logic        fifo_full;       // DUC FIFO full
  logic [47:0] fifo_wrdata;     // {I[23:0], Q[23:0]}
  logic        fifo_wrreq;      // one-cycle write strobe
  logic        seq_error;       // one-cycle sequence mismatch pulse
  logic        packet_done;     // one-cycle full-packet pulse
  logic [31:0] last_seq;        // most recent accepted sequence number
  logic [15:0] seq_err_count;   // saturating
  logic [15:0] overflow_count;  // saturating
  logic [15:0] runt_count;      // saturating

  modport slave (
    input  run, udp_rx_active, udp_rx_data, to_port, fifo_full,
    output fifo_wrdata, fifo_wrreq, seq_error, packet_done, last_seq,
           seq_err_count, overflow_count, runt_count
  );

  modport master (
    output run, udp_rx_active, udp_rx_data, to_port, fifo_full,
    input  fifo_wrdata, fifo_wrreq, seq_error, packet_done, last_seq,
           seq_err_count, overflow_count, runt_count
  );
endinterface

// File: rtl/sdr_receive_duc.sv
// sdr_receive_duc
//   Protocol-2 DUC I/Q receiver. Parses UDP payloads on DUC_PORT: a 32-bit
//   big-endian sequence number followed by SAMPLES pairs of 24-bit I/Q,
//   MSB first. Complete samples are written to the DUC FIFO; sequence gaps,
//   FIFO overflows and runt packets are reported.
//   rx_clock : block clock
//   reset    : asynchronous, active-high
//   bus      : sdr_receive_duc_if.slave (payload in, FIFO write + status out)
module sdr_receive_duc #(
  parameter logic [15:0] DUC_PORT = 16'd1029,
  parameter int          SAMPLES  = 240
) (
  input  logic             rx_clock,
  input  logic             reset,
  sdr_receive_duc_if.slave bus
);

  localparam int             CW        = $clog2(SAMPLES + 1);
  localparam logic [CW-1:0]  LAST_SAMP = CW'(SAMPLES - 1);

  typedef enum logic [1:0] {IDLE, SEQ, SAMPLE, DISCARD} state_t;

  state_t         r_state, w_next;
  logic           r_prev_active;
  logic [2:0]     r_byte_no;
  logic [CW-1:0]  r_samp_cnt;
  logic [23:0]    r_seq;        // first three sequence bytes
  logic [39:0]    r_asm;        // first five bytes of the current sample
  logic           r_seq_valid;
  logic           r_wrreq, r_seq_error, r_pkt_done;
  logic [47:0]    r_wrdata;
  logic [31:0]    r_last_seq;
  logic [15:0]    r_seq_err_cnt, r_ovf_cnt, r_runt_cnt;

  logic w_start, w_first, w_seq_cap, w_seq_last, w_samp, w_word, w_done;
  logic w_runt, w_clr_sv, w_seq_mismatch;
  logic [31:0] w_seq_full;
  logic [47:0] w_word_data;

  // A packet starts only on a rising edge of udp_rx_active; the previous
  // value resets to 1 so a packet cut by reset is never re-parsed.
  assign w_start        = bus.udp_rx_active & ~r_prev_active;
  assign w_seq_full     = {r_seq, bus.udp_rx_data};
  assign w_word_data    = {r_asm, bus.udp_rx_data};
  assign w_seq_mismatch = r_seq_valid && (w_seq_full != r_last_seq + 32'd1);

  always_ff @(posedge rx_clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_first    = 1'b0;
    w_seq_cap  = 1'b0;
    w_seq_last = 1'b0;
    w_samp     = 1'b0;
    w_word     = 1'b0;
    w_done     = 1'b0;
    w_runt     = 1'b0;
    w_clr_sv   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!bus.run) w_clr_sv = 1'b1;
        if (w_start) begin
          if (bus.to_port == DUC_PORT && bus.run) begin
            w_first = 1'b1;
            w_next  = SEQ;
          end else begin
            w_next  = DISCARD;
          end
        end
      end
      SEQ: begin
        if (!bus.udp_rx_active) begin
          w_runt = 1'b1;
          w_next = IDLE;
        end else if (!bus.run) begin
          w_next = DISCARD;
        end else begin
          w_seq_cap = 1'b1;
          if (r_byte_no == 3'd3) begin
            w_seq_last = 1'b1;
            w_next     = SAMPLE;
          end
        end
      end
      SAMPLE: begin
        if (!bus.udp_rx_active) begin
          w_runt = 1'b1;
          w_next = IDLE;
        end else if (!bus.run) begin
          w_next = DISCARD;
        end else begin
          w_samp = 1'b1;
          if (r_byte_no == 3'd5) begin
            w_word = 1'b1;
            if (r_samp_cnt == LAST_SAMP) begin
              w_done = 1'b1;
              w_next = DISCARD;
            end
          end
        end
      end
      DISCARD: if (!bus.udp_rx_active) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge rx_clock or posedge reset) begin
    if (reset) begin
      r_prev_active <= 1'b1;
      r_byte_no     <= '0;
      r_samp_cnt    <= '0;
      r_seq         <= '0;
      r_asm         <= '0;
      r_seq_valid   <= 1'b0;
      r_wrreq       <= 1'b0;
      r_wrdata      <= '0;
      r_seq_error   <= 1'b0;
      r_pkt_done    <= 1'b0;
      r_last_seq    <= '0;
      r_seq_err_cnt <= '0;
      r_ovf_cnt     <= '0;
      r_runt_cnt    <= '0;
    end else begin
      r_prev_active <= bus.udp_rx_active;
      r_wrreq       <= 1'b0;
      r_seq_error   <= 1'b0;
      r_pkt_done    <= w_done;

      // byte_no walks 1..3 through the sequence field, then 0..5 per sample
      if (w_first)                  r_byte_no <= 3'd1;
      else if (w_seq_last || w_word) r_byte_no <= 3'd0;
      else if (w_seq_cap || w_samp)  r_byte_no <= r_byte_no + 3'd1;

      if (w_first)        r_seq <= {16'd0, bus.udp_rx_data};
      else if (w_seq_cap) r_seq <= {r_seq[15:0], bus.udp_rx_data};

      if (w_samp) r_asm <= {r_asm[31:0], bus.udp_rx_data};

      if (w_first)     r_samp_cnt <= '0;
      else if (w_word) r_samp_cnt <= r_samp_cnt + 1'b1;

      if (w_clr_sv) r_seq_valid <= 1'b0;

      if (w_seq_last) begin
        if (w_seq_mismatch) begin
          r_seq_error <= 1'b1;
          if (r_seq_err_cnt != 16'hFFFF) r_seq_err_cnt <= r_seq_err_cnt + 16'd1;
        end
        r_last_seq  <= w_seq_full;
        r_seq_valid <= 1'b1;
      end

      if (w_word) begin
        if (!bus.fifo_full) begin
          r_wrreq  <= 1'b1;
          r_wrdata <= w_word_data;
        end else if (r_ovf_cnt != 16'hFFFF) begin
          r_ovf_cnt <= r_ovf_cnt + 16'd1;
        end
      end

      if (w_runt && r_runt_cnt != 16'hFFFF) r_runt_cnt <= r_runt_cnt + 16'd1;
    end
  end

  assign bus.fifo_wrreq     = r_wrreq;
  assign bus.fifo_wrdata    = r_wrdata;
  assign bus.seq_error      = r_seq_error;
  assign bus.packet_done    = r_pkt_done;
  assign bus.last_seq       = r_last_seq;
  assign bus.seq_err_count  = r_seq_err_cnt;
  assign bus.overflow_count = r_ovf_cnt;
  assign bus.runt_count     = r_runt_cnt;

endmodule

// File: tb/tb_sdr_receive_duc.sv
// tb_sdr_receive_duc
//   Directed bench for sdr_receive_duc: builds payloads byte by byte, keeps
//   a queue of the FIFO words it expects, and checks pulses, counters and
//   data after each step.
module tb_sdr_receive_duc;
  localparam int SAMPLES = 240;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdr_receive_duc_if bus();

  sdr_receive_duc #(.DUC_PORT(16'd1029), .SAMPLES(SAMPLES)) dut (
    .rx_clock (clk),
    .reset    (rst),
    .bus      (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // output monitor, sampled on the falling edge
  int cyc = 0, wr_cnt = 0, done_cnt = 0, serr_cnt = 0, last_wr = 0, done_cyc = -1;
  logic [47:0] act_q[$];
  logic [47:0] exp_q[$];
  int          wcyc_q[$];

  always @(negedge clk) begin
    cyc++;
    if (bus.fifo_wrreq) begin
      act_q.push_back(bus.fifo_wrdata);
      wcyc_q.push_back(cyc);
      wr_cnt++;
      last_wr = cyc;
    end
    if (bus.packet_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.seq_error) serr_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] word(input int n);
    logic [23:0] iv, qv;
    iv = 24'(n);
    qv = 24'(-n);
    return {iv, qv};
  endfunction

  function automatic logic [7:0] pbyte(input int b, input logic [31:0] seq, input int base);
    logic [47:0] w;
    if (b < 4) return seq[8*(3-b) +: 8];
    w = word(base + (b - 4) / 6);
    return w[8*(5 - (b - 4) % 6) +: 8];
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Sends nbytes of a packet; fifo_full is held over samples flo..fhi;
  // reset is pulsed for two bytes starting at byte rst_at (if >= 0).
  task automatic send_pkt(input logic [31:0] seq, input int nbytes, input logic [15:0] port,
                          input int base, input int flo, input int fhi,
                          input int rst_at, input int gap);
    for (int b = 0; b < nbytes; b++) begin
      int s;
      s = (b >= 4) ? (b - 4) / 6 : -1;
      bus.udp_rx_active = 1'b1;
      bus.to_port       = port;
      bus.udp_rx_data   = pbyte(b, seq, base);
      bus.fifo_full     = (s >= flo && s <= fhi);
      if (rst_at >= 0 && b == rst_at)     rst = 1'b1;
      if (rst_at >= 0 && b == rst_at + 2) rst = 1'b0;
      if (b >= 4 && (b - 4) % 6 == 5 && s < SAMPLES && port == 16'd1029 && bus.run &&
          !bus.fifo_full && (rst_at < 0 || b < rst_at))
        exp_q.push_back(word(base + s));
      tick(1);
    end
    bus.udp_rx_active = 1'b0;
    bus.fifo_full     = 1'b0;
    tick(gap);
  endtask

  task automatic chk_data(input string tag);
    chk({tag, "_nwords"}, 64'(act_q.size()), 64'(exp_q.size()));
    while (act_q.size() > 0 && exp_q.size() > 0)
      chk(tag, act_q.pop_front(), exp_q.pop_front());
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic run_cycle();
    bus.run = 1'b0;
    tick(2);
    bus.run = 1'b1;
    tick(1);
  endtask

  initial begin
    int w0, d0, e0, bad;
    bus.run = 1'b0; bus.udp_rx_active = 1'b0; bus.udp_rx_data = 8'h00;
    bus.to_port = 16'd1029; bus.fifo_full = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(2);

    // reset state
    chk("rst_wrreq",  64'(bus.fifo_wrreq), 64'd0);
    chk("rst_wrdata", 64'(bus.fifo_wrdata), 64'd0);
    chk("rst_serr",   64'(bus.seq_error), 64'd0);
    chk("rst_done",   64'(bus.packet_done), 64'd0);
    chk("rst_lseq",   64'(bus.last_seq), 64'd0);
    chk("rst_secnt",  64'(bus.seq_err_count), 64'd0);
    chk("rst_ovf",    64'(bus.overflow_count), 64'd0);
    chk("rst_runt",   64'(bus.runt_count), 64'd0);

    // A: single nominal packet, seq 0, I=n Q=-n
    bus.run = 1'b1; tick(1);
    wcyc_q.delete();
    w0 = wr_cnt; d0 = done_cnt; e0 = serr_cnt;
    send_pkt(32'd0, 1444, 16'd1029, 0, -1, -1, -1, 3);
    chk("A_writes", 64'(wr_cnt - w0), 64'd240);
    chk("A_done",   64'(done_cnt - d0), 64'd1);
    chk("A_serr",   64'(serr_cnt - e0), 64'd0);
    chk("A_lseq",   64'(bus.last_seq), 64'd0);
    chk("A_done_with_last_wr", 64'(done_cyc), 64'(last_wr));
    bad = 0;
    for (int i = 1; i < wcyc_q.size(); i++) if (wcyc_q[i] - wcyc_q[i-1] != 6) bad++;
    chk("A_wr_spacing", 64'(bad), 64'd0);
    chk_data("A_data");

    // B: seq 5, 6, 8 back-to-back with 1-cycle gaps
    run_cycle();
    w0 = wr_cnt; d0 = done_cnt; e0 = serr_cnt;
    send_pkt(32'd5, 1444, 16'd1029, 100, -1, -1, -1, 1);
    send_pkt(32'd6, 1444, 16'd1029, 400, -1, -1, -1, 1);
    send_pkt(32'd8, 1444, 16'd1029, 700, -1, -1, -1, 3);
    chk("B_writes", 64'(wr_cnt - w0), 64'd720);
    chk("B_done",   64'(done_cnt - d0), 64'd3);
    chk("B_serr",   64'(serr_cnt - e0), 64'd1);
    chk("B_secnt",  64'(bus.seq_err_count), 64'd1);
    chk("B_lseq",   64'(bus.last_seq), 64'd8);
    chk_data("B_data");

    // C: wrap FFFFFFFF -> 0, then run toggle and seq 1234
    run_cycle();
    e0 = serr_cnt;
    send_pkt(32'hFFFF_FFFF, 1444, 16'd1029, 5, -1, -1, -1, 1);
    send_pkt(32'd0, 1444, 16'd1029, 6, -1, -1, -1, 2);
    chk("C_wrap_lseq", 64'(bus.last_seq), 64'd0);
    run_cycle();
    send_pkt(32'd1234, 1444, 16'd1029, 7, -1, -1, -1, 3);
    chk("C_serr",  64'(serr_cnt - e0), 64'd0);
    chk("C_secnt", 64'(bus.seq_err_count), 64'd1);
    chk("C_lseq",  64'(bus.last_seq), 64'd1234);
    chk_data("C_data");

    // D: fifo_full over samples 10..19
    w0 = wr_cnt; d0 = done_cnt;
    send_pkt(32'd1235, 1444, 16'd1029, 3000, 10, 19, -1, 3);
    chk("D_ovf",    64'(bus.overflow_count), 64'd10);
    chk("D_writes", 64'(wr_cnt - w0), 64'd230);
    chk("D_done",   64'(done_cnt - d0), 64'd1);
    chk_data("D_data");

    // E: runt truncated at byte 100, then good packet after 1-cycle gap
    w0 = wr_cnt; d0 = done_cnt; e0 = serr_cnt;
    send_pkt(32'd1236, 100, 16'd1029, 4000, -1, -1, -1, 1);
    send_pkt(32'd1237, 1444, 16'd1029, 5000, -1, -1, -1, 3);
    chk("E_runt",   64'(bus.runt_count), 64'd1);
    chk("E_writes", 64'(wr_cnt - w0), 64'd256);
    chk("E_done",   64'(done_cnt - d0), 64'd1);
    chk("E_serr",   64'(serr_cnt - e0), 64'd0);
    chk("E_lseq",   64'(bus.last_seq), 64'd1237);
    chk_data("E_data");

    // F: wrong port ignored, following packet continues the sequence
    w0 = wr_cnt; d0 = done_cnt; e0 = serr_cnt;
    send_pkt(32'd77, 1444, 16'd1025, 6000, -1, -1, -1, 3);
    chk("F_writes", 64'(wr_cnt - w0), 64'd0);
    chk("F_done",   64'(done_cnt - d0), 64'd0);
    chk("F_lseq",   64'(bus.last_seq), 64'd1237);
    send_pkt(32'd1238, 1444, 16'd1029, 7000, -1, -1, -1, 3);
    chk("F_serr",   64'(serr_cnt - e0), 64'd0);
    chk("F_lseq2",  64'(bus.last_seq), 64'd1238);
    chk_data("F_data");

    // G: reset mid-packet, released while udp_rx_active still high
    w0 = wr_cnt; d0 = done_cnt;
    send_pkt(32'd1239, 1444, 16'd1029, 8000, -1, -1, 701, 3);
    chk("G_writes", 64'(wr_cnt - w0), 64'd116);
    chk("G_done",   64'(done_cnt - d0), 64'd0);
    chk("G_secnt",  64'(bus.seq_err_count), 64'd0);
    chk("G_ovf",    64'(bus.overflow_count), 64'd0);
    chk("G_runt",   64'(bus.runt_count), 64'd0);
    chk("G_lseq",   64'(bus.last_seq), 64'd0);
    chk_data("G_data");
    w0 = wr_cnt; d0 = done_cnt; e0 = serr_cnt;
    send_pkt(32'd42, 1444, 16'd1029, 9000, -1, -1, -1, 3);
    chk("G2_writes", 64'(wr_cnt - w0), 64'd240);
    chk("G2_done",   64'(done_cnt - d0), 64'd1);
    chk("G2_serr",   64'(serr_cnt - e0), 64'd0);
    chk("G2_lseq",   64'(bus.last_seq), 64'd42);
    chk_data("G2_data");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
